// File: rtl/riscv_pkg.sv
// Shared RV32I types and constants used by the load/store unit.
// Load/store funct3 encodings, FSM state and access-size enums, request bundle.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RSP,
        RESP
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } mem_size_e;

    typedef struct packed {
        logic            we;
        logic [2:0]      funct3;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [4:0]      rd;
    } lsu_req_t;

    function automatic mem_size_e f3_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Byte-lane steering for stores, load extract/extend, misalign detection.
// Build option LSU_MISALIGN_EXC_EN: flag misaligned accesses instead of aligning.
module riscv_lsu_align
    import riscv_pkg::*;
(
    input  logic            we,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] addr_al,
    output logic [3:0]      be,
    output logic [XLEN-1:0] st_data,
    output logic [XLEN-1:0] ld_data,
    output logic            illegal,
    output logic            fault
);

    mem_size_e       size;
    logic [1:0]      off;
    logic [XLEN-1:0] shifted;

    assign size = f3_size(funct3);

    assign illegal = we ? (funct3 > 3'd2)
                        : (funct3 == 3'd3 || funct3[2:1] == 2'b11);

`ifdef LSU_MISALIGN_EXC_EN
    assign fault = ~illegal
                 & (((size == SZ_H) & addr[0])
                  | ((size == SZ_W) & (|addr[1:0])));
`else
    assign fault = 1'b0;
`endif

    // Without the exception option, misaligned addresses are rounded down.
    always_comb begin
        addr_al = addr;
        unique case (1'b1)
            (size == SZ_H): addr_al[0]   = 1'b0;
            (size == SZ_W): addr_al[1:0] = 2'b00;
            default: ;
        endcase
    end

    assign off = addr_al[1:0];

    always_comb begin
        be      = 4'b1111;
        st_data = wdata;
        unique case (1'b1)
            (size == SZ_B): begin
                st_data = {4{wdata[7:0]}};
                if (we) be = 4'b0001 << off;
            end
            (size == SZ_H): begin
                st_data = {2{wdata[15:0]}};
                if (we) be = off[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    assign shifted = rdata >> {off, 3'b000};

    always_comb begin
        ld_data = '0;
        unique case (funct3)
            F3_LB:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LW:  ld_data = shifted;
            F3_LBU: ld_data = {24'd0, shifted[7:0]};
            F3_LHU: ld_data = {16'd0, shifted[15:0]};
            default: ld_data = '0;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// RV32I load/store unit: execute request -> req/gnt/rvalid memory -> write-back pulse.
// Build option LSU_MISALIGN_EXC_EN: misaligned H/W accesses raise exc_o.
module riscv_lsu
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [XLEN-1:0]   req_addr_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    input  logic [4:0]        req_rd_i,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i,
    output logic              wb_valid_o,
    output logic              wb_we_o,
    output logic [4:0]        wb_rd_o,
    output logic [XLEN-1:0]   wb_data_o,
    output logic              exc_o
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_REQ  = REQ;
    localparam logic [1:0] S_WAIT = WAIT_RSP;
    localparam logic [1:0] S_RESP = RESP;

    logic [1:0]        state_q;
    lsu_req_t          req_q;
    lsu_req_t          cur;

    logic              mem_we_q;
    logic [3:0]        mem_be_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [XLEN-1:0]   mem_wdata_q;
    logic              wb_we_q;
    logic [4:0]        wb_rd_q;
    logic [XLEN-1:0]   wb_data_q;
    logic              exc_q;

    logic [XLEN-1:0]   al_addr;
    logic [3:0]        al_be;
    logic [XLEN-1:0]   al_wdata;
    logic [XLEN-1:0]   al_ld;
    logic              al_illegal;
    logic              al_fault;

    assign req_ready_o = (state_q == S_IDLE);
    assign mem_req_o   = (state_q == S_REQ);
    assign wb_valid_o  = (state_q == S_RESP);

    // Align unit sees the incoming op while idle, the latched op afterwards.
    always_comb begin
        cur = req_q;
        if (req_ready_o) begin
            cur.we     = req_we_i;
            cur.funct3 = req_funct3_i;
            cur.addr   = req_addr_i;
            cur.wdata  = req_wdata_i;
            cur.rd     = req_rd_i;
        end
    end

    riscv_lsu_align u_align (
        .we      (cur.we),
        .funct3  (cur.funct3),
        .addr    (cur.addr),
        .wdata   (cur.wdata),
        .rdata   (mem_rdata_i),
        .addr_al (al_addr),
        .be      (al_be),
        .st_data (al_wdata),
        .ld_data (al_ld),
        .illegal (al_illegal),
        .fault   (al_fault)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            req_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            exc_q       <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        req_q   <= cur;
                        wb_rd_q <= req_rd_i;
                        if (al_illegal || al_fault) begin
                            state_q   <= S_RESP;
                            wb_we_q   <= 1'b0;
                            wb_data_q <= al_fault ? req_addr_i : '0;
                            exc_q     <= al_fault;
                        end else begin
                            state_q     <= S_REQ;
                            mem_we_q    <= req_we_i;
                            mem_be_q    <= al_be;
                            mem_addr_q  <= ADDR_W'({al_addr[XLEN-1:2], 2'b00});
                            mem_wdata_q <= al_wdata;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt_i) begin
                        mem_we_q    <= 1'b0;
                        mem_be_q    <= '0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        if (req_q.we) begin
                            state_q   <= S_RESP;
                            wb_we_q   <= 1'b0;
                            wb_data_q <= '0;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid_i) begin
                        state_q   <= S_RESP;
                        wb_data_q <= al_ld;
                        wb_we_q   <= (req_q.rd != 5'd0);
                    end
                end
                S_RESP: begin
                    state_q   <= S_IDLE;
                    wb_we_q   <= 1'b0;
                    wb_rd_q   <= '0;
                    wb_data_q <= '0;
                    exc_q     <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_we_o    = mem_we_q;
    assign mem_be_o    = mem_be_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign wb_we_o     = wb_we_q;
    assign wb_rd_o     = wb_rd_q;
    assign wb_data_o   = wb_data_q;
    assign exc_o       = exc_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Randomized scoreboard bench for riscv_lsu with a byte-level reference model.
// Honours LSU_MISALIGN_EXC_EN to match whichever build is under test.
module tb_riscv_lsu;
    import riscv_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [4:0]  req_rd_i;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        wb_valid_o;
    logic        wb_we_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        exc_o;

    always #5 clk_i = ~clk_i;

    riscv_lsu #(.ADDR_W(32)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_funct3_i (req_funct3_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_rd_i     (req_rd_i),
        .mem_req_o    (mem_req_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .wb_valid_o   (wb_valid_o),
        .wb_we_o      (wb_we_o),
        .wb_rd_o      (wb_rd_o),
        .wb_data_o    (wb_data_o),
        .exc_o        (exc_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } mem_exp_t;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exc;
    } wb_exp_t;

    mem_exp_t mem_q[$];
    wb_exp_t  wb_q[$];
    int n_vec = 0;
    int n_err = 0;
    int stall_ovr = -1;
    int rsp_ovr = -1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: event seen/missing, expected otherwise", name);
    endtask

    function automatic void model(
        input  logic        we,
        input  logic [2:0]  f3,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  logic [4:0]  rd,
        input  logic [31:0] rdata,
        output logic        acc,
        output mem_exp_t    m,
        output wb_exp_t     w
    );
        int nb;
        int off;
        bit ill;
        bit mis;
        logic [31:0] a;
        logic [31:0] v;
        nb  = 1 << f3[1:0];
        ill = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5);
        mis = 1'b0;
`ifdef LSU_MISALIGN_EXC_EN
        mis = !ill && (addr % nb != 0);
`endif
        a   = addr - addr % nb;
        off = int'(a % 4);
        acc = !ill && !mis;
        m.addr  = a & 32'hFFFF_FFFC;
        m.we    = we;
        m.rdata = rdata;
        m.be    = we ? 4'(((1 << nb) - 1) << off) : 4'hF;
        for (int i = 0; i < 4; i++)
            m.wdata[8*i +: 8] = wdata[8*(i % nb) +: 8];
        v = 32'd0;
        for (int k = 0; k < nb && k < 4; k++)
            v[8*k +: 8] = rdata[8*(off+k) +: 8];
        if (!f3[2] && nb < 4 && v[8*nb-1])
            v = v | ~((32'h1 << (8*nb)) - 1);
        w.rd  = rd;
        w.exc = mis;
        if (mis) begin
            w.we   = 1'b0;
            w.data = addr;
        end else if (ill || we) begin
            w.we   = 1'b0;
            w.data = 32'd0;
        end else begin
            w.we   = (rd != 5'd0);
            w.data = v;
        end
    endfunction

    task automatic monitor();
        wb_exp_t e;
        forever begin
            @(negedge clk_i);
            if (wb_valid_o) begin
                if (wb_q.size() == 0) begin
                    fail("wb_unexpected");
                end else begin
                    e = wb_q.pop_front();
                    chk("wb_we", wb_we_o, e.we);
                    chk("wb_data", wb_data_o, e.data);
                    chk("wb_exc", exc_o, e.exc);
                    if (e.we) chk("wb_rd", wb_rd_o, e.rd);
                end
            end else if (exc_o) begin
                fail("exc_without_wb");
            end
        end
    endtask

    task automatic responder();
        mem_exp_t    cur;
        bit          have = 0;
        bit          pend = 0;
        int          stall = 0;
        int          dly = 0;
        logic [31:0] rdv = 0;
        forever begin
            @(negedge clk_i);
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = $urandom;
            if (pend) begin
                if (dly == 0) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = rdv;
                    pend = 0;
                end else begin
                    dly--;
                end
            end
            if (mem_gnt_i) begin
                mem_gnt_i = 1'b0;
            end else if (mem_req_o) begin
                if (!have && mem_q.size() == 0) begin
                    fail("mem_unexpected");
                    mem_gnt_i = 1'b1;
                end else begin
                    if (!have) begin
                        cur   = mem_q.pop_front();
                        have  = 1;
                        stall = (stall_ovr >= 0) ? stall_ovr : $urandom_range(0, 3);
                    end
                    chk("mem_we", mem_we_o, cur.we);
                    chk("mem_addr", mem_addr_o, cur.addr);
                    chk("mem_be", mem_be_o, cur.be);
                    if (cur.we) chk("mem_wdata", mem_wdata_o, cur.wdata);
                    if (stall == 0) begin
                        mem_gnt_i = 1'b1;
                        have = 0;
                        if (!cur.we) begin
                            pend = 1;
                            dly  = (rsp_ovr >= 0) ? rsp_ovr : $urandom_range(0, 2);
                            rdv  = cur.rdata;
                        end
                    end else begin
                        stall--;
                    end
                end
            end
        end
    endtask

    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd, input logic [31:0] rdata);
        logic     acc;
        mem_exp_t m;
        wb_exp_t  w;
        int       t = 0;
        model(we, f3, addr, wdata, rd, rdata, acc, m, w);
        if (acc) mem_q.push_back(m);
        wb_q.push_back(w);
        @(negedge clk_i);
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_funct3_i = f3;
        req_addr_i   = addr;
        req_wdata_i  = wdata;
        req_rd_i     = rd;
        while (!req_ready_o && t < 200) begin
            @(negedge clk_i);
            t++;
        end
        if (t >= 200) fail("accept_timeout");
        @(negedge clk_i);
        req_valid_i  = 1'b0;
        req_addr_i   = $urandom;
        req_wdata_i  = $urandom;
    endtask

    task automatic drain();
        int t = 0;
        while ((wb_q.size() != 0 || mem_q.size() != 0 || !req_ready_o) && t < 500) begin
            @(negedge clk_i);
            t++;
        end
        if (t >= 500) begin
            fail("drain_timeout");
            wb_q.delete();
            mem_q.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i        = 1'b1;
        req_valid_i  = 1'b0;
        req_we_i     = 1'b0;
        req_funct3_i = 3'd0;
        req_addr_i   = 32'd0;
        req_wdata_i  = 32'd0;
        req_rd_i     = 5'd0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'd0;
        fork monitor(); join_none
        repeat (3) @(negedge clk_i);

        chk("rst_ready", req_ready_o, 1);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_mem_we", mem_we_o, 0);
        chk("rst_mem_be", mem_be_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_wdata", mem_wdata_o, 0);
        chk("rst_wb_valid", wb_valid_o, 0);
        chk("rst_wb_we", wb_we_o, 0);
        chk("rst_wb_rd", wb_rd_o, 0);
        chk("rst_wb_data", wb_data_o, 0);
        chk("rst_exc", exc_o, 0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // reset while waiting for read data; late rvalid must be ignored
        req_valid_i  = 1'b1;
        req_we_i     = 1'b0;
        req_funct3_i = F3_LW;
        req_addr_i   = 32'h40;
        req_rd_i     = 5'd3;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        chk("rst_req_on", mem_req_o, 1);
        mem_gnt_i = 1'b1;
        @(negedge clk_i);
        mem_gnt_i = 1'b0;
        rst_i = 1'b1;
        #1;
        chk("rstw_mem_req", mem_req_o, 0);
        chk("rstw_ready", req_ready_o, 1);
        chk("rstw_wb_valid", wb_valid_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hCAFEF00D;
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            chk("rst_no_wb", wb_valid_o, 0);
        end

        // reset while requesting; mem_req_o must drop at once
        req_valid_i = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        chk("rst2_req_on", mem_req_o, 1);
        rst_i = 1'b1;
        #1;
        chk("rst2_req_drop", mem_req_o, 0);
        chk("rst2_be_clr", mem_be_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        fork responder(); join_none

        stall_ovr = 0;
        rsp_ovr   = 0;
        issue(1'b1, F3_SB, 32'h103, 32'h0000_00A5, 5'd0, 32'd0);
        @(negedge clk_i);
        chk("sb_latency", wb_valid_o, 1);
        drain();
        issue(1'b0, F3_LB, 32'h202, 32'd0, 5'd5, 32'h12F0_3456);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("lb_latency", wb_valid_o, 1);
        drain();
        issue(1'b0, F3_LBU, 32'h202, 32'd0, 5'd5, 32'h12F0_3456);
        drain();
        stall_ovr = 3;
        issue(1'b0, F3_LH, 32'h206, 32'd0, 5'd7, 32'h8001_1234);
        drain();
        stall_ovr = 0;
        issue(1'b0, F3_LW, 32'h400, 32'd0, 5'd0, 32'hDEAD_BEEF);
        drain();
        issue(1'b0, F3_LW, 32'h301, 32'd0, 5'd9, 32'h1122_3344);
        drain();
        issue(1'b1, F3_SH, 32'h503, 32'h0000_BEEF, 5'd0, 32'd0);
        issue(1'b0, 3'd3, 32'h600, 32'd0, 5'd4, 32'd0);
        issue(1'b1, 3'd5, 32'h604, 32'h1234_5678, 5'd0, 32'd0);
        issue(1'b0, F3_LHU, 32'h702, 32'd0, 5'd31, 32'h9ABC_DEF0);
        drain();

        stall_ovr = -1;
        rsp_ovr   = -1;
        repeat (300) begin
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  32'($urandom_range(0, 4095)), $urandom,
                  5'($urandom_range(0, 31)), $urandom);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Load/store unit that sits directly downstream of the RV32I execute stage and upstream of write-back. It takes one load or store per request from execute: effective address, funct3, store data and rd. It drives a req/gnt/rvalid data-memory port with byte enables, then aligns and extends load data. Each operation completes as a single write-back pulse that the register-file write-back stage consumes.

Parameters:
XLEN, 32, data/address width (from riscv_pkg)
ADDR_W, 32, memory address width; mem_addr_o is word aligned (bits [1:0] = 0)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-high reset
req_valid_i  in  1  execute has a memory op
req_ready_o  out  1  LSU can accept; high only in IDLE
req_we_i  in  1  1 = store, 0 = load
req_funct3_i  in  3  F3_LB/LH/LW/LBU/LHU or F3_SB/SH/SW
req_addr_i  in  XLEN  effective address (rs1+imm)
req_wdata_i  in  XLEN  rs2 data (stores)
req_rd_i  in  5  destination register (loads)
mem_req_o  out  1  memory request
mem_gnt_i  in  1  memory accepted request this cycle
mem_we_o  out  1  write request
mem_be_o  out  4  byte enables
mem_addr_o  out  ADDR_W  word-aligned address
mem_wdata_o  out  XLEN  lane-shifted store data
mem_rvalid_i  in  1  read data valid
mem_rdata_i  in  XLEN  raw word read data
wb_valid_o  out  1  one-cycle completion pulse
wb_we_o  out  1  write rd (loads with rd!=0 only)
wb_rd_o  out  5  destination register
wb_data_o  out  XLEN  aligned, extended load result
exc_o  out  1  misaligned-access pulse (only with LSU_MISALIGN_EXC_EN; tied 0 otherwise)

Behaviour:
- Reset (async, rst_i=1): state IDLE. req_ready_o=1. All other outputs 0: mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, exc_o.
- Reset mid-operation: mem_req_o drops immediately and any pending op is dropped. An mem_rvalid_i arriving after reset releases, while in IDLE, is ignored.
- FSM IDLE -> REQ -> (WAIT_RSP) -> RESP -> IDLE:
  - IDLE: handshake is req_valid_i & req_ready_o. On handshake, latch we/funct3/addr/wdata/rd and go to REQ.
  - REQ: mem_req_o=1. mem_we_o, mem_be_o, mem_addr_o and mem_wdata_o are registered and held stable until mem_gnt_i. If mem_gnt_i is low, stay.
    - Gnt on a store: go to RESP.
    - Gnt on a load: go to WAIT_RSP.
  - WAIT_RSP: mem_req_o=0. On mem_rvalid_i, capture the extracted data into wb_data_o and go to RESP. rvalid never arrives in the same cycle as gnt.
  - RESP: wb_valid_o=1 for exactly this cycle, then IDLE.
- Minimum latency with immediate gnt/rvalid:
  - load: accept c0, req+gnt c1, rvalid c2, wb_valid_o c3, ready c4.
  - store: accept c0, req+gnt c1, wb_valid_o c2, ready c3.
- Byte enables and write data:
  - SB: be = 1<<addr[1:0]; wdata = byte replicated x4.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = half replicated x2.
  - SW: be = 4'b1111.
  - Loads drive be = 4'b1111.
- Load extract: shifted = rdata >> (8*addr[1:0]). LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW takes the full word.
- wb_we_o = load & rd!=0 & no exception. Stores pulse wb_valid_o with wb_we_o=0 and wb_data_o=0.
- Illegal funct3 (load 3/6/7, store >=3): no memory access. Go IDLE -> RESP directly; wb_valid_o pulse with wb_we_o=0.

Optional Feature:
LSU_MISALIGN_EXC_EN.
- Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, make no memory access. Go to RESP; exc_o=1 together with wb_valid_o, wb_we_o=0, wb_data_o = faulting address.
- Undefined: the address is forced aligned (halfword clears bit 0, word clears [1:0]) and the access proceeds normally. exc_o is constant 0.

Decomposition:
- riscv_pkg additions:
  - lsu_state_e {IDLE, REQ, WAIT_RSP, RESP}
  - mem_size_e {SZ_B, SZ_H, SZ_W}
  - lsu_req_t struct (we, funct3, addr, wdata, rd)
  - existing F3_LB…F3_SW constants are reused
- One combinational sub-module, riscv_lsu_align: store be/wdata generation, load extract/extend, misalign detect.

Test Plan:
- Reset: rst_i pulse mid-WAIT_RSP with rvalid 2 cycles later -> mem_req_o=0 immediately, no wb_valid_o, req_ready_o=1.
- SB addr=0x103, wdata=0x000000A5, gnt immediate -> mem_addr_o=0x100, mem_be_o=4'b1000, mem_wdata_o=0xA5A5A5A5; wb_valid_o at c2 with wb_we_o=0.
- LB addr=0x202, rdata=0x12F03456, rd=5 -> wb_data_o=0xFFFFFFF0, wb_we_o=1, wb_rd_o=5. Same access as LBU -> 0x000000F0.
- LH addr=0x206, rdata=0x80011234, gnt held low 3 cycles -> request fields stable through the stall; wb_data_o=0xFFFF8001 after rvalid.
- LW rd=0, rdata=0xDEADBEEF -> wb_valid_o=1, wb_we_o=0.
- LW addr=0x301:
  - with LSU_MISALIGN_EXC_EN: no mem_req_o, exc_o=1, wb_data_o=0x301.
  - without: mem_addr_o=0x300 and a normal load.
